// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and lane helpers for the MEM stage.
package mem_access_pkg;

    localparam int RegBus = 32;
    localparam int RegAddrBus = 5;
    localparam logic [RegBus-1:0] ZeroWord = 32'h0;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [7:0] TimeoutLimit = 8'd255;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        BUS           = 2'd1,
        TIMEOUT_ABORT = 2'd2
    } state_t;

    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
    } wb_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [RegBus-1:0] addr;
        logic [RegBus-1:0] wdata;
        logic [3:0]        sel;
    } bus_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP,
                          EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic misaligned(input logic [7:0] op,
                                        input logic [1:0] a);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[0];
            EXE_LW_OP, EXE_SW_OP:             return a != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

    // Big-endian lanes: sel[3] is the byte at offset 0.
    function automatic logic [3:0] sel_for(input logic [7:0] op,
                                           input logic [1:0] a);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 4'b1000 >> a;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[1] ? 4'b0011 : 4'b1100;
            default:                          return 4'b1111;
        endcase
    endfunction

    function automatic logic [RegBus-1:0] wdata_for(input logic [7:0] op,
                                                    input logic [RegBus-1:0] d);
        case (op)
            EXE_SB_OP: return {4{d[7:0]}};
            EXE_SH_OP: return {2{d[15:0]}};
            EXE_SW_OP: return d;
            default:   return ZeroWord;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Picks the addressed byte/half out of a big-endian read word and
// sign- or zero-extends it to 32 bits.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [7:0]        op,
    input  logic [1:0]        addr,
    input  logic [RegBus-1:0] rdata,
    output logic [RegBus-1:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (addr)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = addr[1] ? rdata[15:0] : rdata[31:16];
        case (op)
            EXE_LB_OP:  value = {{24{b[7]}}, b};
            EXE_LBU_OP: value = {24'h0, b};
            EXE_LH_OP:  value = {{16{h[15]}}, h};
            EXE_LHU_OP: value = {16'h0, h};
            EXE_LW_OP:  value = rdata;
            default:    value = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues one data-bus transaction per load/store, stalls the
// pipeline until ack, and aborts with bus_err after a fixed wait limit.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [7:0]            mem_aluop,
    input  logic [RegBus-1:0]     mem_addr,
    input  logic [RegBus-1:0]     mem_reg2,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [RegBus-1:0]     wb_wdata,
    output logic                  d_req,
    output logic                  d_we,
    output logic [RegBus-1:0]     d_addr,
    output logic [RegBus-1:0]     d_wdata,
    output logic [3:0]            d_sel,
    input  logic                  d_ack,
    input  logic [RegBus-1:0]     d_rdata,
    output logic                  stallreq,
    input  logic                  flush,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic                  bus_err
);

    state_t                state;
    logic [7:0]            cnt;
    logic                  kill;
    logic [7:0]            op_q;
    logic [1:0]            lane_q;
    logic [RegAddrBus-1:0] wd_q;
    logic                  wreg_q;
    wb_t                   wb;
    bus_t                  bus;
    logic [RegBus-1:0]     ld_value;
    logic                  is_mem;
    logic                  bad;

    load_extend u_ext (
        .op    (op_q),
        .addr  (lane_q),
        .rdata (d_rdata),
        .value (ld_value)
    );

    assign is_mem = is_load(mem_aluop) | is_store(mem_aluop);
    assign bad    = is_mem & misaligned(mem_aluop, mem_addr[1:0]);

    // Gated by rst so the stall reads low throughout reset.
    assign stallreq = rst &
        ((state == IDLE && is_mem && !flush && !bad) ||
         (state == BUS && !d_ack));

    assign wb_wd    = wb.wd;
    assign wb_wreg  = wb.wreg;
    assign wb_wdata = wb.wdata;
    assign d_req    = bus.req;
    assign d_we     = bus.we;
    assign d_addr   = bus.addr;
    assign d_wdata  = bus.wdata;
    assign d_sel    = bus.sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            kill     <= 1'b0;
            op_q     <= 8'd0;
            lane_q   <= 2'd0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wb       <= '0;
            bus      <= '0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        wb <= '0;
                    end else if (!is_mem) begin
                        wb <= '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata};
                    end else if (bad) begin
                        wb       <= '0;
                        exc_adel <= is_load(mem_aluop);
                        exc_ades <= is_store(mem_aluop);
                    end else begin
                        wb        <= '0;
                        bus.req   <= 1'b1;
                        bus.we    <= is_store(mem_aluop);
                        bus.addr  <= {mem_addr[31:2], 2'b00};
                        bus.wdata <= wdata_for(mem_aluop, mem_reg2);
                        bus.sel   <= sel_for(mem_aluop, mem_addr[1:0]);
                        op_q      <= mem_aluop;
                        lane_q    <= mem_addr[1:0];
                        wd_q      <= mem_wd;
                        wreg_q    <= mem_wreg;
                        cnt       <= 8'd0;
                        kill      <= 1'b0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    if (flush) kill <= 1'b1;
                    if (d_ack) begin
                        bus   <= '0;
                        kill  <= 1'b0;
                        state <= IDLE;
                        if (kill || flush || is_store(op_q))
                            wb <= '0;
                        else
                            wb <= '{wd: wd_q, wreg: wreg_q, wdata: ld_value};
                    end else if (cnt == TimeoutLimit) begin
                        bus     <= '0;
                        wb      <= '0;
                        bus_err <= 1'b1;
                        state   <= TIMEOUT_ABORT;
                    end else begin
                        wb  <= '0;
                        cnt <= cnt + 8'd1;
                    end
                end
                TIMEOUT_ABORT: begin
                    wb    <= '0;
                    kill  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed vector bench for the MEM stage plus hand-written sequences
// for timeout, ack-in-idle and asynchronous reset.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        stallreq;
    logic        flush;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sel(d_sel), .d_ack(d_ack), .d_rdata(d_rdata),
        .stallreq(stallreq), .flush(flush),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int cur = -1;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        logic [4:0]  wd;
        logic [7:0]  dly;
        logic        fi;
        logic        fb;
        logic        bus;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] bwd;
        logic        wreg;
        logic [31:0] res;
        logic        adel;
        logic        ades;
        logic [7:0]  stalls;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL v%0d %s: got %h, want %h", cur, name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        mem_aluop = 8'h00;
        mem_wreg  = 1'b0;
        mem_wd    = 5'd0;
        mem_wdata = 32'h0;
        mem_addr  = 32'h0;
        mem_reg2  = 32'h0;
        flush     = 1'b0;
        d_ack     = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        int st;
        int bad;
        logic [31:0] ea;
        ea = {t.addr[31:2], 2'b00};
        st = 0;
        bad = 0;
        mem_aluop = t.op;
        mem_addr  = t.addr;
        mem_reg2  = t.reg2;
        mem_wdata = t.reg2;
        mem_wd    = t.wd;
        mem_wreg  = 1'b1;
        flush     = t.fi;
        d_rdata   = t.rdata;
        d_ack     = 1'b0;
        #1;
        if (stallreq) st++;
        tick;
        flush = 1'b0;
        if (t.bus) begin
            chk("req", {31'h0, d_req}, 32'h1);
            chk("we", {31'h0, d_we}, {31'h0, t.we});
            chk("sel", {28'h0, d_sel}, {28'h0, t.sel});
            chk("addr", d_addr, ea);
            if (t.we) chk("bus_wdata", d_wdata, t.bwd);
            for (int i = 0; i < int'(t.dly); i++) begin
                if (t.fb && i == 0) flush = 1'b1;
                #1;
                if (stallreq) st++;
                tick;
                flush = 1'b0;
                if (d_req !== 1'b1 || d_sel !== t.sel ||
                    d_addr !== ea || d_we !== t.we)
                    bad++;
            end
            chk("req_hold", bad, 0);
            if (t.fb && t.dly == 0) flush = 1'b1;
            d_ack = 1'b1;
            #1;
            if (stallreq) st++;
            tick;
            d_ack = 1'b0;
            flush = 1'b0;
            chk("req_drop", {31'h0, d_req}, 32'h0);
        end else begin
            chk("no_req", {31'h0, d_req}, 32'h0);
        end
        chk("stall_cycles", st, {24'h0, t.stalls});
        chk("wb_wreg", {31'h0, wb_wreg}, {31'h0, t.wreg});
        if (t.wreg) begin
            chk("wb_wd", {27'h0, wb_wd}, {27'h0, t.wd});
            chk("wb_wdata", wb_wdata, t.res);
        end
        chk("adel", {31'h0, exc_adel}, {31'h0, t.adel});
        chk("ades", {31'h0, exc_ades}, {31'h0, t.ades});
        nop;
        tick;
        chk("exc_pulse", {30'h0, exc_adel, exc_ades}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int bad;
        // op addr reg2 rdata wd dly fi fb | bus we sel bwd wreg res adel ades stalls
        v[0]  = '{8'h25, 32'h0,   32'h1234,     32'h0,        5'd5,  8'd0, 1'b0, 1'b0,
                  1'b0, 1'b0, 4'h0,    32'h0,        1'b1, 32'h1234,     1'b0, 1'b0, 8'd0};
        v[1]  = '{8'hE0, 32'h103, 32'h0,        32'h000000F0, 5'd3,  8'd0, 1'b0, 1'b0,
                  1'b1, 1'b0, 4'b0001, 32'h0,        1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 8'd1};
        v[2]  = '{8'hE9, 32'h102, 32'h0000ABCD, 32'h0,        5'd4,  8'd3, 1'b0, 1'b0,
                  1'b1, 1'b1, 4'b0011, 32'hABCDABCD, 1'b0, 32'h0,        1'b0, 1'b0, 8'd4};
        v[3]  = '{8'hE3, 32'h101, 32'h0,        32'h0,        5'd6,  8'd0, 1'b0, 1'b0,
                  1'b0, 1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 8'd0};
        v[4]  = '{8'hE5, 32'h100, 32'h0,        32'h80011234, 5'd7,  8'd2, 1'b0, 1'b1,
                  1'b1, 1'b0, 4'b1100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 8'd3};
        v[5]  = '{8'hE4, 32'h101, 32'h0,        32'h12F35678, 5'd8,  8'd1, 1'b0, 1'b0,
                  1'b1, 1'b0, 4'b0100, 32'h0,        1'b1, 32'h000000F3, 1'b0, 1'b0, 8'd2};
        v[6]  = '{8'hE1, 32'h102, 32'h0,        32'h00008001, 5'd9,  8'd0, 1'b0, 1'b0,
                  1'b1, 1'b0, 4'b0011, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0, 8'd1};
        v[7]  = '{8'hE3, 32'h104, 32'h0,        32'hDEADBEEF, 5'd10, 8'd1, 1'b0, 1'b0,
                  1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'd2};
        v[8]  = '{8'hE8, 32'h101, 32'h1234565A, 32'h0,        5'd11, 8'd0, 1'b0, 1'b0,
                  1'b1, 1'b1, 4'b0100, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b0, 1'b0, 8'd1};
        v[9]  = '{8'hEB, 32'h108, 32'hCAFEF00D, 32'h0,        5'd12, 8'd2, 1'b0, 1'b0,
                  1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b0, 8'd3};
        v[10] = '{8'hE9, 32'h103, 32'h1,        32'h0,        5'd13, 8'd0, 1'b0, 1'b0,
                  1'b0, 1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 8'd0};
        v[11] = '{8'hE3, 32'h200, 32'h0,        32'h0,        5'd14, 8'd0, 1'b1, 1'b0,
                  1'b0, 1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 8'd0};
        v[12] = '{8'hE1, 32'h101, 32'h0,        32'h0,        5'd15, 8'd0, 1'b1, 1'b0,
                  1'b0, 1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 8'd0};
        v[13] = '{8'hE1, 32'h100, 32'h0,        32'h7FFF0000, 5'd16, 8'd0, 1'b0, 1'b0,
                  1'b1, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h00007FFF, 1'b0, 1'b0, 8'd1};
        v[14] = '{8'h25, 32'h0,   32'h55,       32'h0,        5'd17, 8'd0, 1'b1, 1'b0,
                  1'b0, 1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 8'd0};

        rst = 1'b0;
        nop;
        d_rdata = 32'h0;
        mem_aluop = 8'hE3;
        mem_addr = 32'h40;
        #3;
        chk("rst_stall", {31'h0, stallreq}, 32'h0);
        chk("rst_wb", {wb_wd, wb_wreg, 26'h0}, 32'h0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        chk("rst_bus", {d_req, d_we, d_sel, exc_adel, exc_ades, bus_err, 23'h0}, 32'h0);
        chk("rst_addr", d_addr | d_wdata, 32'h0);
        nop;
        #9;
        rst = 1'b1;
        tick;

        for (int i = 0; i < 15; i++) begin
            cur = i;
            run_vec(v[i]);
        end

        cur = 100;
        mem_aluop = 8'h25;
        mem_wd = 5'd2;
        mem_wreg = 1'b1;
        mem_wdata = 32'h9;
        d_ack = 1'b1;
        #1;
        chk("idle_ack_stall", {31'h0, stallreq}, 32'h0);
        tick;
        chk("idle_ack_req", {31'h0, d_req}, 32'h0);
        chk("idle_ack_wb", wb_wdata, 32'h9);
        nop;
        tick;

        cur = 101;
        mem_aluop = 8'hE3;
        mem_addr = 32'h300;
        mem_wd = 5'd20;
        mem_wreg = 1'b1;
        tick;
        bad = 0;
        for (int k = 1; k <= 255; k++) begin
            if (d_req !== 1'b1 || stallreq !== 1'b1 || bus_err !== 1'b0) bad++;
            tick;
        end
        chk("to_wait_cycles", bad, 0);
        chk("to_req256", {31'h0, d_req}, 32'h1);
        chk("to_stall256", {31'h0, stallreq}, 32'h1);
        tick;
        chk("to_bus_err", {31'h0, bus_err}, 32'h1);
        chk("to_req_drop", {31'h0, d_req}, 32'h0);
        chk("to_stall_abort", {31'h0, stallreq}, 32'h0);
        tick;
        mem_aluop = 8'h25;
        mem_wd = 5'd21;
        mem_wdata = 32'h77;
        chk("to_err_pulse", {31'h0, bus_err}, 32'h0);
        chk("to_bubble", {31'h0, wb_wreg}, 32'h0);
        #1;
        chk("to_resume_stall", {31'h0, stallreq}, 32'h0);
        tick;
        chk("to_resume_wb", {wb_wd, wb_wreg, 26'h0}, {5'd21, 1'b1, 26'h0});
        chk("to_resume_data", wb_wdata, 32'h77);
        nop;
        tick;

        cur = 102;
        mem_aluop = 8'hEB;
        mem_addr = 32'h400;
        mem_reg2 = 32'h11223344;
        mem_wd = 5'd22;
        mem_wreg = 1'b1;
        tick;
        chk("mid_req", {31'h0, d_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_bus", {d_req, d_we, d_sel, 26'h0}, 32'h0);
        chk("mid_rst_addr", d_addr, 32'h0);
        chk("mid_rst_wdata", d_wdata, 32'h0);
        chk("mid_rst_stall", {31'h0, stallreq}, 32'h0);
        nop;
        tick;
        #2;
        rst = 1'b1;
        tick;
        chk("post_rst", {d_req, wb_wreg, stallreq, 29'h0}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: rst  in  1  asynchronous active-low reset; rst==0 resets immediately, independent of clk.
REQ-003 SHALL expose, from the EX/MEM register: mem_wd in 5 (dest reg), mem_wreg in 1, mem_wdata in 32 (ALU result), mem_aluop in 8, mem_addr in 32, mem_reg2 in 32 (store data).
REQ-004 SHALL expose, to MEM/WB: wb_wd out 5, wb_wreg out 1, wb_wdata out 32.
REQ-005 SHALL expose a data-bus master port: d_req out 1, d_we out 1, d_addr out 32 (word-aligned), d_wdata out 32, d_sel out 4 (byte lanes, big-endian, sel[3]=addr byte 0), d_ack in 1, d_rdata in 32.
REQ-006 SHALL expose: stallreq out 1 (freeze upstream), flush in 1 (kill current op), exc_adel out 1, exc_ades out 1, bus_err out 1 (one-cycle pulses).

Function
REQ-007 SHALL decode mem_aluop into LB, LBU, LH, LHU, LW, SB, SH, SW; every other code is a non-memory op.
REQ-008 Non-memory op, no flush: SHALL register wb_* <= mem_wd/mem_wreg/mem_wdata at the next edge; stallreq=0; one-cycle latency.
REQ-009 SHALL implement FSM states IDLE, BUS, TIMEOUT_ABORT; reset state IDLE.
REQ-010 IDLE with an aligned memory op: SHALL register d_addr={mem_addr[31:2],2'b00}, d_we, d_sel, lane-replicated d_wdata, go to BUS; stallreq=1 combinationally in this cycle.
REQ-011 Alignment: LH/LHU/SH SHALL require addr[0]==0; LW/SW SHALL require addr[1:0]==0; a misaligned load/store SHALL pulse exc_adel/exc_ades, issue no bus cycle, write a bubble (wb_wreg=0), stay in IDLE, stallreq=0.
REQ-012 BUS: d_req SHALL be 1 and d_addr/d_we/d_sel/d_wdata SHALL stay stable until the cycle d_ack==1; stallreq = !d_ack.
REQ-013 Ack cycle: SHALL drop d_req at the next edge, return to IDLE, and register wb_*: loads write the selected byte/half sign- (LB/LH) or zero-extended (LBU/LHU), or the full word (LW), with wb_wreg=mem_wreg; stores write wb_wreg=0.
REQ-014 A d_ack arriving in IDLE SHALL be ignored.
REQ-015 An 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without d_ack; at 255, SHALL go to TIMEOUT_ABORT, drop d_req, and pulse bus_err.
REQ-016 TIMEOUT_ABORT SHALL last one cycle, write a bubble, deassert stallreq, then return to IDLE.
REQ-017 flush in IDLE SHALL write a bubble and start no bus cycle.
REQ-018 flush in BUS SHALL NOT abort the bus cycle. It SHALL be latched into a kill flag, and the completing result SHALL be written as a bubble.
REQ-019 Simultaneous flush and misaligned address SHALL suppress the exception pulse.

Reset
REQ-020 While rst==0, SHALL drive: state=IDLE, wait counter=0, kill flag=0, wb_wd=5'b0, wb_wreg=0, wb_wdata=32'h0, d_req=0, d_we=0, d_addr=0, d_wdata=0, d_sel=4'b0, exc/bus_err=0; stallreq SHALL read 0.
REQ-021 Reset mid-BUS SHALL abandon the transaction immediately. No result is written after release.

Structure
REQ-022 The aluop codes for the eight load/store ops, the state encoding, and the timeout limit (255) SHALL live in the shared macros file, next to RegBus/RegAddrBus/ZeroWord.
REQ-023 Load-data alignment and extension SHALL be one combinational sub-module, load_extend (inputs: op, addr[1:0], d_rdata; output: 32-bit value).

Verification
REQ-024 Non-memory op: aluop=OR, wd=5, wdata=32'h1234 -> one edge later wb_wd=5, wb_wdata=32'h1234, stallreq never high.
REQ-025 LB at addr 0x103, d_rdata=32'h000000F0, ack on first BUS cycle -> wb_wdata=32'hFFFFFFF0, stall exactly 1 cycle, d_sel=4'b0001.
REQ-026 SH at addr 0x102, reg2=32'hABCD, ack after 3 wait cycles -> d_wdata=32'hABCDABCD, d_sel=4'b0011, request stable 4 cycles, wb_wreg=0.
REQ-027 LW at addr 0x101 -> exc_adel pulse, d_req never asserted, wb_wreg=0.
REQ-028 LW with no ack -> bus_err pulse at BUS cycle 256, d_req drops, pipeline resumes.
REQ-029 flush asserted during BUS of LHU, then ack -> wb_wreg=0. Separately: rst low mid-BUS -> all outputs zero asynchronously.
